// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the LC-3 internal bus: source indices, gate one-hots and arbiter states.
package lc3_bus_pkg;

  localparam logic [2:0] BUS_IDX_PC     = 3'd0;
  localparam logic [2:0] BUS_IDX_MDR    = 3'd1;
  localparam logic [2:0] BUS_IDX_ALU    = 3'd2;
  localparam logic [2:0] BUS_IDX_MARMUX = 3'd3;
  localparam logic [2:0] BUS_IDX_VECTOR = 3'd4;
  localparam logic [2:0] BUS_IDX_PC_M1  = 3'd5;
  localparam logic [2:0] BUS_IDX_PSR    = 3'd6;
  localparam logic [2:0] BUS_IDX_SP     = 3'd7;

  localparam logic [7:0] GATE_NONE   = 8'h00;
  localparam logic [7:0] GATE_PC     = 8'h01;
  localparam logic [7:0] GATE_MDR    = 8'h02;
  localparam logic [7:0] GATE_ALU    = 8'h04;
  localparam logic [7:0] GATE_MARMUX = 8'h08;
  localparam logic [7:0] GATE_VECTOR = 8'h10;
  localparam logic [7:0] GATE_PC_M1  = 8'h20;
  localparam logic [7:0] GATE_PSR    = 8'h40;
  localparam logic [7:0] GATE_SP     = 8'h80;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StTurn
  } bus_state_e;

  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    return 8'h01 << idx;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/gate bundle between the LC-3 bus drivers (master side) and the bus arbiter (slave side).
interface bus_arbiter_if;
  logic [7:0] req;
  logic       flush;
  logic [7:0] gate_bus;
  logic [2:0] owner;
  logic       bus_busy;
  logic       gnt_new;

  modport master (
    output req,
    output flush,
    input  gate_bus,
    input  owner,
    input  bus_busy,
    input  gnt_new
  );

  modport slave (
    input  req,
    input  flush,
    output gate_bus,
    output owner,
    output bus_busy,
    output gnt_new
  );
endinterface

// File: rtl/bus_arbiter_rr_pick8.sv
// 8-way priority picker: first set request at or after start_i, wrapping modulo 8.
module rr_pick8 (
  input  logic [7:0] req_i,
  input  logic [2:0] start_i,
  output logic [2:0] idx_o,
  output logic       valid_o
);

  logic [2:0] cand;
  logic       found;

  always_comb begin
    idx_o = 3'd0;
    found = 1'b0;
    cand  = 3'd0;
    for (int i = 0; i < 8; i++) begin
      cand = start_i + 3'(i);
      if (!found && req_i[cand]) begin
        idx_o = cand;
        found = 1'b1;
      end
    end
    valid_o = |req_i;
  end

endmodule

// File: rtl/bus_arbiter.sv
// LC-3 internal bus arbiter: burst-limited grants with turnaround gaps, registered one-hot gate.
// Define BUS_ARB_RR_EN for round-robin selection; otherwise lowest index wins.
module bus_arbiter
  import lc3_bus_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned TURN_CYC  = 1
) (
  input logic          clk,
  input logic          rst,
  bus_arbiter_if.slave bus
);

  localparam logic [3:0] MaxBurstW = 4'(MAX_BURST);
  localparam logic [1:0] TurnW     = 2'(TURN_CYC);

  bus_state_e state_q, state_d;
  logic [7:0] gate_q, gate_d;
  logic [2:0] owner_q, owner_d;
  logic       busy_q, busy_d;
  logic       gnt_new_q, gnt_new_d;
  logic [3:0] burst_q, burst_d;
  logic [1:0] turn_q, turn_d;
  logic       mask_q, mask_d;

  logic       do_grant;
  logic       expiry;
  logic       arb_mask;
  logic [7:0] other_req;
  logic [7:0] arb_req;
  logic [2:0] start_idx;
  logic [2:0] pick_idx;
  logic       pick_valid;

`ifdef BUS_ARB_RR_EN
  logic [2:0] ptr_q, ptr_d;

  assign start_idx = ptr_q + 3'd1;
  assign ptr_d     = do_grant ? pick_idx : ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 3'd7;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign start_idx = 3'd0;
`endif

  // Owner that burned its full burst yields to any other requester in the next arbitration.
  assign expiry    = bus.req[owner_q] && (burst_q >= MaxBurstW);
  assign arb_mask  = ((state_q == StGrant) && expiry) || ((state_q == StTurn) && mask_q);
  assign other_req = bus.req & ~onehot8(owner_q);
  assign arb_req   = (arb_mask && (|other_req)) ? other_req : bus.req;

  rr_pick8 u_pick (
    .req_i   (arb_req),
    .start_i (start_idx),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      gate_q    <= GATE_NONE;
      owner_q   <= BUS_IDX_SP;
      busy_q    <= 1'b0;
      gnt_new_q <= 1'b0;
      burst_q   <= 4'd0;
      turn_q    <= 2'd0;
      mask_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gate_q    <= gate_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
      gnt_new_q <= gnt_new_d;
      burst_q   <= burst_d;
      turn_q    <= turn_d;
      mask_q    <= mask_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    burst_d  = burst_q;
    turn_d   = turn_q;
    mask_d   = mask_q;
    do_grant = 1'b0;
    if (bus.flush) begin
      state_d = StIdle;
      burst_d = 4'd0;
      turn_d  = 2'd0;
      mask_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            state_d  = StGrant;
            burst_d  = 4'd1;
            do_grant = 1'b1;
          end
        end
        StGrant: begin
          if (bus.req[owner_q] && (burst_q < MaxBurstW)) begin
            burst_d = burst_q + 4'd1;
          end else if (TURN_CYC == 0) begin
            if (pick_valid) begin
              burst_d  = 4'd1;
              do_grant = 1'b1;
            end else begin
              state_d = StIdle;
              burst_d = 4'd0;
            end
          end else begin
            state_d = StTurn;
            burst_d = 4'd0;
            turn_d  = 2'd1;
            mask_d  = expiry;
          end
        end
        StTurn: begin
          if (turn_q == TurnW) begin
            turn_d = 2'd0;
            mask_d = 1'b0;
            if (pick_valid) begin
              state_d  = StGrant;
              burst_d  = 4'd1;
              do_grant = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end else begin
            turn_d = turn_q + 2'd1;
          end
        end
        default: begin
          state_d = StIdle;
          burst_d = 4'd0;
          turn_d  = 2'd0;
          mask_d  = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    gate_d    = gate_q;
    owner_d   = owner_q;
    gnt_new_d = 1'b0;
    if (do_grant) begin
      owner_d   = pick_idx;
      gate_d    = onehot8(pick_idx);
      gnt_new_d = 1'b1;
    end else if (state_d != StGrant) begin
      gate_d = GATE_NONE;
    end
    busy_d = |gate_d;
  end

  assign bus.gate_bus = gate_q;
  assign bus.owner    = owner_q;
  assign bus.bus_busy = busy_q;
  assign bus.gnt_new  = gnt_new_q;

  gate_onehot_a: assert property (@(posedge clk) disable iff (rst) $onehot0(gate_q));

endmodule
